// File: rtl/orbit_frame_writer_if.sv
// Sample input and frame-RAM write bus of the orbit frame writer.
// The sample source drives the master side and the writer is the slave.
interface orbit_frame_writer_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 11
);
  logic [DATA_W-1:0] iData;
  logic              iVal;
  logic [ADDR_W:0]   oWrAddr;
  logic [DATA_W:0]   oWrData;
  logic              oWrEn;

  modport master (
    output iData, iVal,
    input  oWrAddr, oWrData, oWrEn
  );

  modport slave (
    input  iData, iVal,
    output oWrAddr, oWrData, oWrEn
  );
endinterface

// File: rtl/orbit_frame_writer.sv
// Writes telemetry samples into the ping-pong frame bank that the
// serializer is not reading, and tracks drops and short frames.
module orbit_frame_writer #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 11,
  parameter int CNT_W  = 8
) (
  input  logic                 iClkOrb,
  input  logic                 reset,
  orbit_frame_writer_if.slave  bus,
  input  logic                 iSwitch,
  output logic                 oReady,
  output logic                 oFull,
  output logic                 oFrameStart,
  output logic [CNT_W-1:0]     oDropCnt,
  output logic [CNT_W-1:0]     oShortCnt
);

  typedef enum logic {FILL, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST = '1;

  state_t            state;
  state_t            state_nx;
  logic              sw_prev;
  logic              sw_edge;
  logic              bank;
  logic              bank_nx;
  logic              wr_bank;
  logic              accept;
  logic              drop_inc;
  logic              short_inc;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] idx_nx;
  logic [ADDR_W-1:0] wr_idx;

  assign sw_edge = iSwitch ^ sw_prev;

  // FSM state register
  always_ff @(posedge iClkOrb) begin
    if (!reset) state <= FILL;
    else        state <= state_nx;
  end

  // Next state, write selection and counter strobes
  always_comb begin
    state_nx  = state;
    bank_nx   = bank;
    idx_nx    = idx;
    wr_bank   = bank;
    wr_idx    = idx;
    accept    = 1'b0;
    drop_inc  = 1'b0;
    short_inc = 1'b0;
    if (sw_edge) begin
      state_nx  = FILL;
      bank_nx   = ~iSwitch;
      wr_bank   = ~iSwitch;
      wr_idx    = '0;
      idx_nx    = '0;
      short_inc = (state == FILL);
      if (bus.iVal) begin
        accept = 1'b1;
        idx_nx = ADDR_W'(1);
      end
    end else if (bus.iVal) begin
      if (state == FILL) begin
        accept = 1'b1;
        if (idx == LAST) state_nx = DONE;
        else             idx_nx   = idx + ADDR_W'(1);
      end else begin
        drop_inc = 1'b1;
      end
    end
  end

  // Datapath registers, registered write port and status outputs
  always_ff @(posedge iClkOrb) begin
    if (!reset) begin
      sw_prev     <= 1'b0;
      bank        <= 1'b1;
      idx         <= '0;
      bus.oWrEn   <= 1'b0;
      bus.oWrAddr <= '0;
      bus.oWrData <= '0;
      oReady      <= 1'b1;
      oFull       <= 1'b0;
      oFrameStart <= 1'b0;
      oDropCnt    <= '0;
      oShortCnt   <= '0;
    end else begin
      sw_prev     <= iSwitch;
      bank        <= bank_nx;
      idx         <= idx_nx;
      bus.oWrEn   <= accept;
      if (accept) begin
        bus.oWrAddr <= {wr_bank, wr_idx};
        bus.oWrData <= {1'b0, bus.iData};
      end
      oReady      <= (state_nx == FILL);
      oFull       <= (state_nx == DONE);
      oFrameStart <= sw_edge;
      if (drop_inc && oDropCnt != '1)
        oDropCnt <= oDropCnt + CNT_W'(1);
      if (short_inc && oShortCnt != '1)
        oShortCnt <= oShortCnt + CNT_W'(1);
    end
  end

endmodule
